e_bin2dec: RTL and testbench
============================

Name: e_bin2dec

Overview:
- Downstream stage of the e squaring calculator.
- Takes the finished multi-word fixed-point result (integer word plus fraction words) and converts it to decimal digits, one per handshake: integer digit first, then NUM_DIGITS fraction digits.
- Each fraction digit is produced by repeatedly multiplying the fraction by 10, one 16-bit word per cycle. Digits stream to a display/UART formatter over a valid/ready interface.

Parameters:
- WORDS, 32: number of 16-bit words in in_data. Word 0 is the integer part; words 1..WORDS-1 are the fraction, most significant first.
- NUM_DIGITS, 100: fraction digits emitted per conversion; legal range 1..(WORDS-1)*4.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin conversion; sampled only in IDLE or DONE
- in_data  input  16 x [0:WORDS-1]  fixed-point value; word 0 integer, words 1.. fraction MSW-first
- digit  output  8  BCD in [3:0] with [7:4]=0, or ASCII when the option is enabled
- digit_valid  output  1  digit holds a valid symbol
- digit_ready  input  1  consumer accepts the symbol
- busy  output  1  conversion in progress (state not IDLE/DONE)
- done  output  1  high in DONE until the next accepted start
- ovf  output  1  integer word was >9 at load; held until the next start

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; digit=0, digit_valid=0, busy=0, done=0, ovf=0; fraction buffer, carry and counters all 0.
- States: IDLE, EMIT_INT, [EMIT_DOT], MUL, EMIT_FRAC, DONE.
- IDLE/DONE + start:
  - Copy words 1..WORDS-1 into the fraction buffer.
  - Latch ovf = (in_data[0] > 9).
  - Clear digit_cnt; clear done.
  - Next state EMIT_INT.
- start while busy is ignored. The in_data snapshot is taken only at the accepted start.
- EMIT_INT:
  - digit = in_data[0][3:0] as latched, or 9 if ovf is set; digit_valid=1.
  - On digit_valid && digit_ready: go to EMIT_DOT if ASCII is enabled, else MUL.
- MUL (word index w runs WORDS-1 down to 1, one word per cycle):
  - p = frac[w]*10 + carry, 20 bits wide.
  - frac[w] <= p[15:0]; carry <= p[19:16].
  - carry starts at 0 for w=WORDS-1.
  - Exactly WORDS-1 cycles, then EMIT_FRAC.
  - Final carry is the digit; its value is always 0..9.
- EMIT_FRAC:
  - digit = carry; digit_valid=1.
  - On handshake, digit_cnt++.
  - If digit_cnt == NUM_DIGITS-1 at that handshake, go to DONE; else MUL with carry cleared.
- Latency from start to first digit_valid is 1 cycle. From each fraction-digit request to valid is WORDS-1 cycles of MUL plus 1.
- Backpressure: while digit_valid=1 and digit_ready=0, digit and state hold stable indefinitely. digit_valid is never deasserted without a handshake.
- digit_ready with digit_valid=0 has no effect.
- DONE: digit_valid=0, done=1, busy=0. start in DONE restarts exactly as from IDLE.
- A zero fraction yields all-zero digits; there is no early termination.
- Reset mid-conversion aborts immediately. No partial digit is emitted after reset deasserts.

Optional Feature:
- Macro: E_BIN2DEC_ASCII_EN.
- Defined:
  - digit carries ASCII: '0'+value, i.e. 0x30..0x39.
  - EMIT_DOT state sends '.' (0x2E) after the integer digit, under the same handshake rules.
  - Total symbols per conversion = NUM_DIGITS+2.
- Undefined:
  - digit carries BCD; EMIT_DOT is not compiled.
  - Total symbols = NUM_DIGITS+1.

Test Plan:
1. WORDS=4, NUM_DIGITS=4, in_data={2,0x8000,0,0}, ready=1 -> digits 2,5,0,0,0; done=1 after the last handshake; ovf=0.
2. WORDS=4, in_data={2,0x4000,0,0}, ready held low 5 cycles on the first fraction digit -> digit stays 2 (valid) with state unchanged, then sequence 2,2,5,0,0.
3. WORDS=32, default NUM_DIGITS, in_data = e computed to 496 bits -> first digits 2,7,1,8,2,8,1,8,2,8 match the golden model for all 100 digits.
4. in_data[0]=12 -> ovf=1 and first digit 9; a later start with in_data[0]=3 clears ovf.
5. Assert rst during the MUL of digit 3 -> all outputs return to reset values within the same cycle; a new start converts correctly; start pulsed while busy is ignored.
6. With E_BIN2DEC_ASCII_EN, in_data={2,0x8000,0,0}, NUM_DIGITS=2 -> symbols 0x32,0x2E,0x35,0x30, then done.

Source files
------------

// File: rtl/e_bin2dec.sv
// e_bin2dec -- converts a multi-word fixed-point value to a stream of decimal digits.
//
// The value is WORDS 16-bit words: word 0 is the integer part, words 1..WORDS-1
// are the binary fraction, most significant word first. One symbol is emitted per
// valid/ready handshake: the integer digit, then NUM_DIGITS fraction digits. Each
// fraction digit comes from multiplying the whole fraction by 10, one word per
// cycle from the least significant word upwards; the carry out of the top word is
// the next decimal digit.
//
// Optional macro E_BIN2DEC_ASCII_EN: symbols are ASCII ('0'+value) and a '.'
// symbol follows the integer digit. Undefined: symbols are BCD in digit[3:0].
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a conversion (accepted only in IDLE or DONE)
//   in_data         WORDS x 16-bit value, sampled at the accepted start
//   digit           current symbol (BCD or ASCII)
//   digit_valid     digit holds a valid symbol
//   digit_ready     consumer accepts the symbol
//   busy            conversion in progress
//   done            conversion finished, held until the next accepted start
//   ovf             integer word was >9 at load; integer digit saturates to 9
module e_bin2dec #(
  parameter int WORDS      = 32,
  parameter int NUM_DIGITS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in_data [0:WORDS-1],
  output logic [7:0]  digit,
  output logic        digit_valid,
  input  logic        digit_ready,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  localparam int WW = (WORDS > 2) ? $clog2(WORDS) : 1;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [WW-1:0] W_LAST   = WW'(WORDS - 1);
  localparam logic [WW-1:0] W_FIRST  = WW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EMIT_INT  = 3'd1,
`ifdef E_BIN2DEC_ASCII_EN
    EMIT_DOT  = 3'd2,
`endif
    MUL       = 3'd3,
    EMIT_FRAC = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t        state_reg;
  logic [15:0]   frac_reg [1:WORDS-1];
  logic [3:0]    carry_reg;
  logic [WW-1:0] w_reg;
  logic [CW-1:0] digit_cnt_reg;
  logic [19:0]   prod;
  logic          ovf_next;

  // Encode a 0..9 value as the output symbol.
  function automatic logic [7:0] sym(input logic [3:0] v);
`ifdef E_BIN2DEC_ASCII_EN
    return {4'h3, v};
`else
    return {4'h0, v};
`endif
  endfunction

  // One word of the x10 pass; the upper nibble is the carry into the next word.
  assign prod     = ({4'd0, frac_reg[w_reg]} * 20'd10) + {16'd0, carry_reg};
  assign ovf_next = (in_data[0] > 16'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      for (int i = 1; i < WORDS; i++) frac_reg[i] <= 16'd0;
      carry_reg     <= 4'd0;
      w_reg         <= '0;
      digit_cnt_reg <= '0;
      digit         <= 8'd0;
      digit_valid   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            for (int i = 1; i < WORDS; i++) frac_reg[i] <= in_data[i];
            ovf           <= ovf_next;
            digit_cnt_reg <= '0;
            done          <= 1'b0;
            busy          <= 1'b1;
            carry_reg     <= 4'd0;
            w_reg         <= W_LAST;
            digit         <= sym(ovf_next ? 4'd9 : in_data[0][3:0]);
            digit_valid   <= 1'b1;
            state_reg     <= EMIT_INT;
          end
        end

        EMIT_INT: begin
          if (digit_ready) begin
`ifdef E_BIN2DEC_ASCII_EN
            digit     <= 8'h2E;
            state_reg <= EMIT_DOT;
`else
            digit_valid <= 1'b0;
            carry_reg   <= 4'd0;
            w_reg       <= W_LAST;
            state_reg   <= MUL;
`endif
          end
        end

`ifdef E_BIN2DEC_ASCII_EN
        EMIT_DOT: begin
          if (digit_ready) begin
            digit_valid <= 1'b0;
            carry_reg   <= 4'd0;
            w_reg       <= W_LAST;
            state_reg   <= MUL;
          end
        end
`endif

        MUL: begin
          frac_reg[w_reg] <= prod[15:0];
          carry_reg       <= prod[19:16];
          if (w_reg == W_FIRST) begin
            // Carry out of the top fraction word is the next decimal digit.
            digit       <= sym(prod[19:16]);
            digit_valid <= 1'b1;
            state_reg   <= EMIT_FRAC;
          end else begin
            w_reg <= w_reg - W_FIRST;
          end
        end

        EMIT_FRAC: begin
          if (digit_ready) begin
            digit_valid   <= 1'b0;
            digit_cnt_reg <= digit_cnt_reg + CW'(1);
            if (digit_cnt_reg == CNT_LAST) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              carry_reg <= 4'd0;
              w_reg     <= W_LAST;
              state_reg <= MUL;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_bin2dec.sv
// Testbench for e_bin2dec: a small instance (4 words, 4 digits) driven from a
// hand-computed vector table and random vectors, and a full-size instance
// converting e. Expected symbols come from a big-number model of the fraction.
module tb_e_bin2dec;

`ifdef E_BIN2DEC_ASCII_EN
  localparam int DOT = 1;
`else
  localparam int DOT = 0;
`endif

  localparam int SW = 4, SND = 4;
  localparam int BW = 32, BND = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit   sel = 1'b0;          // 0: small instance, 1: full-size instance
  logic tb_start = 1'b0, tb_ready = 1'b0;

  logic [15:0] s_in [0:SW-1];
  logic [15:0] b_in [0:BW-1];
  logic [7:0]  s_digit, b_digit;
  logic s_valid, s_busy, s_done, s_ovf, b_valid, b_busy, b_done, b_ovf;
  logic s_start, b_start, s_ready, b_ready;

  assign s_start = tb_start & ~sel;
  assign b_start = tb_start & sel;
  assign s_ready = tb_ready & ~sel;
  assign b_ready = tb_ready & sel;

  wire [7:0] c_digit = sel ? b_digit : s_digit;
  wire       c_valid = sel ? b_valid : s_valid;
  wire       c_busy  = sel ? b_busy  : s_busy;
  wire       c_done  = sel ? b_done  : s_done;
  wire       c_ovf   = sel ? b_ovf   : s_ovf;

  e_bin2dec #(.WORDS(SW), .NUM_DIGITS(SND)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .in_data(s_in),
    .digit(s_digit), .digit_valid(s_valid), .digit_ready(s_ready),
    .busy(s_busy), .done(s_done), .ovf(s_ovf));

  e_bin2dec #(.WORDS(BW), .NUM_DIGITS(BND)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_data(b_in),
    .digit(b_digit), .digit_valid(b_valid), .digit_ready(b_ready),
    .busy(b_busy), .done(b_done), .ovf(b_ovf));

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit exp_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] sym(input int v);
`ifdef E_BIN2DEC_ASCII_EN
    return 8'(8'h30 + v);
`else
    return 8'(v);
`endif
  endfunction

  // Reference: treat the fraction as one big binary number F/2^nbits; each digit
  // is floor(F*10 / 2^nbits), then F keeps the remainder.
  task automatic build_exp(input int w0, input logic [511:0] frac, input int nbits, input int nd);
    logic [511:0] f, mask;
    int d;
    f = frac;
    mask = (512'd1 << nbits) - 512'd1;
    exp_q.delete();
    exp_ovf = (w0 > 9);
    exp_q.push_back(sym(exp_ovf ? 9 : w0));
    if (DOT != 0) exp_q.push_back(8'h2E);
    for (int k = 0; k < nd; k++) begin
      f = f * 10;
      d = int'(f >> nbits);
      f = f & mask;
      exp_q.push_back(sym(d));
    end
  endtask

  // Start a conversion on the selected instance, collect symbols, compare to exp_q.
  task automatic run_conv(input string tag, input int rdy_pct, input int stall_idx, input bit inject);
    bit prev_stall;
    logic [7:0] prev_digit;
    int stall_cnt, cyc;
    got_q.delete();
    prev_stall = 0; prev_digit = 8'd0; stall_cnt = 0;
    @(negedge clk); tb_start = 1'b1; tb_ready = 1'b0;
    @(negedge clk); tb_start = 1'b0;
    chk({tag, " first_valid"}, 32'(c_valid), 32'd1);
    chk({tag, " busy"}, 32'(c_busy), 32'd1);
    chk({tag, " ovf"}, 32'(c_ovf), 32'(exp_ovf));
    for (cyc = 0; cyc < 20000; cyc++) begin
      if (c_done) break;
      if (prev_stall) begin
        chk({tag, " hold_valid"}, 32'(c_valid), 32'd1);
        chk({tag, " hold_digit"}, 32'(c_digit), 32'(prev_digit));
      end
      if (inject && cyc == 3) begin
        tb_start = 1'b1;
        s_in[0] = 16'd7; s_in[1] = 16'hFFFF;
      end else begin
        tb_start = 1'b0;
      end
      if (got_q.size() == stall_idx && c_valid && stall_cnt < 5) begin
        tb_ready = 1'b0; stall_cnt++;
      end else begin
        tb_ready = ($urandom_range(99) < rdy_pct);
      end
      if (c_valid && tb_ready) got_q.push_back(c_digit);
      prev_stall = c_valid && !tb_ready;
      prev_digit = c_digit;
      @(negedge clk);
    end
    tb_start = 1'b0; tb_ready = 1'b0;
    chk({tag, " done_within_budget"}, 32'(c_done), 32'd1);
    chk({tag, " valid_after_done"}, 32'(c_valid), 32'd0);
    chk({tag, " busy_after_done"}, 32'(c_busy), 32'd0);
    chk({tag, " symbol_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) chk($sformatf("%s sym%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    n_cmp++;  // whole-sequence comparison
    if (got_q != exp_q) begin
      n_bad++;
      $display("FAIL %s sequence: got %p expected %p", tag, got_q, exp_q);
    end
    $display("%s: %0d symbols, ovf=%0d", tag, got_q.size(), c_ovf);
  endtask

  typedef struct packed {
    logic [63:0] w;    // {word0, word1, word2, word3}
    logic [19:0] dg;   // expected {int digit, frac1..frac4} nibbles
    logic        ov;
  } vec_t;

  vec_t tbl [7];

  task automatic load_small(input logic [63:0] w);
    for (int i = 0; i < SW; i++) s_in[i] = w[63 - 16*i -: 16];
  endtask

  task automatic exp_from_table(input vec_t v);
    exp_q.delete();
    exp_ovf = v.ov;
    exp_q.push_back(sym(int'(v.dg[19:16])));
    if (DOT != 0) exp_q.push_back(8'h2E);
    for (int k = 1; k <= SND; k++) exp_q.push_back(sym(int'(v.dg[19 - 4*k -: 4])));
  endtask

  initial begin
    logic [543:0] x, one;
    logic [511:0] fr;
    int cnt, guard;
    int e_digits [10];
    logic [63:0] rw;

    tbl[0] = '{w: 64'h0002_8000_0000_0000, dg: 20'h25000, ov: 1'b0};
    tbl[1] = '{w: 64'h0002_4000_0000_0000, dg: 20'h22500, ov: 1'b0};
    tbl[2] = '{w: 64'h000C_8000_0000_0000, dg: 20'h95000, ov: 1'b1};
    tbl[3] = '{w: 64'h0003_0000_0000_0000, dg: 20'h30000, ov: 1'b0};
    tbl[4] = '{w: 64'h0000_FFFF_FFFF_FFFF, dg: 20'h09999, ov: 1'b0};
    tbl[5] = '{w: 64'h0009_1999_9999_9999, dg: 20'h90999, ov: 1'b0};
    tbl[6] = '{w: 64'h0001_2000_0000_0000, dg: 20'h11250, ov: 1'b0};
    e_digits = '{2, 7, 1, 8, 2, 8, 1, 8, 2, 8};

    load_small(64'd0);
    for (int i = 0; i < BW; i++) b_in[i] = 16'd0;

    repeat (3) @(negedge clk);
    chk("reset digit", 32'(s_digit), 32'd0);
    chk("reset valid", 32'(s_valid), 32'd0);
    chk("reset busy", 32'(s_busy), 32'd0);
    chk("reset done", 32'(s_done), 32'd0);
    chk("reset ovf", 32'(s_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Hand-computed vectors; entry 1 stalls on the first fraction digit.
    for (int t = 0; t < 7; t++) begin
      load_small(tbl[t].w);
      exp_from_table(tbl[t]);
      run_conv($sformatf("tbl%0d", t), 100, (t == 1) ? 1 + DOT : -1, 1'b0);
    end

    // Random vectors with random backpressure against the big-number model.
    for (int t = 0; t < 20; t++) begin
      rw = {16'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom)};
      load_small(rw);
      build_exp(int'(rw[63:48]), {464'd0, rw[47:0]}, 48, SND);
      run_conv($sformatf("rnd%0d", t), 60, -1, 1'b0);
    end

    // start pulsed while busy (with different in_data) must be ignored.
    load_small(64'h0002_8000_0000_0000);
    build_exp(2, {464'd0, 48'h8000_0000_0000}, 48, SND);
    run_conv("busy_start", 100, -1, 1'b1);

    // Reset during the x10 pass of fraction digit 3.
    load_small(64'h0002_8000_0000_0000);
    @(negedge clk); tb_start = 1'b1; tb_ready = 1'b1;
    @(negedge clk); tb_start = 1'b0;
    cnt = 0;
    for (guard = 0; guard < 200; guard++) begin
      if (cnt == 3 + DOT && !s_valid) break;
      if (s_valid) cnt++;
      @(negedge clk);
    end
    chk("rst reached_mul", 32'(cnt), 32'(3 + DOT));
    #2 rst = 1'b1;
    #1;
    chk("rst async valid", 32'(s_valid), 32'd0);
    chk("rst async busy", 32'(s_busy), 32'd0);
    chk("rst async digit", 32'(s_digit), 32'd0);
    chk("rst async done", 32'(s_done), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (s_valid || s_busy) chk("rst no_partial", 32'({s_valid, s_busy}), 32'd0);
    end
    chk("rst idle valid", 32'(s_valid), 32'd0);
    tb_ready = 1'b0;
    load_small(64'h0001_2000_0000_0000);
    exp_from_table(tbl[6]);
    run_conv("after_rst", 100, -1, 1'b0);

    // e to 496 fraction bits via Horner: e = 1 + 1/1(1 + 1/2(1 + ...)).
    one = 544'd1 << 528;
    x = one;
    for (int k = 110; k >= 1; k--) x = one + x / k;
    b_in[0] = x[543:528];
    for (int i = 1; i < BW; i++) b_in[i] = x[528 - 16*i +: 16];
    fr = {16'd0, x[527:32]};
    build_exp(int'(x[543:528]), fr, 496, BND);
    sel = 1'b1;
    run_conv("e", 80, -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      int gi;
      gi = (i == 0) ? 0 : i + DOT;
      if (gi < got_q.size()) chk($sformatf("e const%0d", i), 32'(got_q[gi]), 32'(sym(e_digits[i])));
      else chk($sformatf("e const%0d missing", i), 32'(got_q.size()), 32'(gi + 1));
    end
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
